// File: rtl/uart_pkg.sv
// Shared UART definitions: default data width and a constant-foldable log2 helper.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  // Ceiling log2, usable in parameter and port-width expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers and occupancy count.
// Head data is presented combinationally from the read pointer.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = UART_DATA_BITS,
  parameter int DEPTH = 4,
  localparam int ADDR_W = clog2(DEPTH),
  localparam int LEVEL_W = clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [WIDTH-1:0]   push_data,
  input  logic               pop,
  output logic [WIDTH-1:0]   head_data,
  output logic               full,
  output logic               empty,
  output logic [LEVEL_W-1:0] level
);

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  rd_ptr;
  logic [LEVEL_W-1:0] count;
  logic               do_push;
  logic               do_pop;

  // Pushes into a full FIFO and pops from an empty one are silently dropped.
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign full      = (count == LEVEL_W'(DEPTH));
  assign empty     = (count == '0);
  assign level     = count;
  assign head_data = mem[rd_ptr];

  // Pointer and count update; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register reading pre-edge values,
    // so the order of statements inside clocked blocks does not matter.
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + LEVEL_W'(1);
        2'b01:   count <= count - LEVEL_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; the count guards every
    // read, so stale contents are never observed and the array maps to plain RAM.
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/tx_word_fifo_serializer.sv
// UART TX word buffer: queues parallel words and shifts them out one bit per
// rd_enable strobe, chaining consecutive words without an idle strobe.
module tx_word_fifo_serializer
  import uart_pkg::*;
#(
  parameter int WORD_SIZE = UART_DATA_BITS,
  parameter int DEPTH     = 4,
  parameter int MSB_FIRST = 0,
  localparam int LEVEL_W  = clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] wr_data,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic                 rd_enable,
  output logic                 data_serial_out,
  output logic                 word_last,
  output logic                 underrun,
  output logic                 empty,
  output logic                 full,
  output logic [LEVEL_W-1:0]   fifo_level
);

  localparam int BL_W = clog2(WORD_SIZE + 1);

  logic [WORD_SIZE-1:0] shifter;
  logic [WORD_SIZE-1:0] shifter_next;
  logic [BL_W-1:0]      bits_left;
  logic [WORD_SIZE-1:0] head_data;
  logic                 fifo_empty;
  logic                 have_bits;
  logic                 shift_en;
  logic                 last_shift;
  logic                 load_en;
  logic                 next_bit;

  sync_fifo #(
    .WIDTH (WORD_SIZE),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_valid),
    .push_data (wr_data),
    .pop       (load_en),
    .head_data (head_data),
    .full      (full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Load when the shifter is idle, or when the final bit leaves this edge.
  assign have_bits  = (bits_left != '0);
  assign shift_en   = rd_enable && have_bits;
  assign last_shift = shift_en && (bits_left == BL_W'(1));
  assign load_en    = !fifo_empty && (!have_bits || last_shift);

  assign wr_ready = !full;
  assign empty    = fifo_empty && !have_bits;

  // Bit order selection: the outgoing bit and the shift direction share one end.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign next_bit     = shifter[WORD_SIZE-1];
      assign shifter_next = shifter << 1;
    end else begin : g_lsb_first
      assign next_bit     = shifter[0];
      assign shifter_next = shifter >> 1;
    end
  endgenerate

  // Shifter, bit counter and registered serial outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      shifter         <= '0;
      bits_left       <= '0;
      data_serial_out <= 1'b0;
      word_last       <= 1'b0;
      underrun        <= 1'b0;
    end else begin
      word_last <= last_shift;
      underrun  <= rd_enable && !have_bits;
      if (shift_en) data_serial_out <= next_bit;
      if (load_en) begin
        shifter   <= head_data;
        bits_left <= BL_W'(WORD_SIZE);
      end else if (shift_en) begin
        shifter   <= shifter_next;
        bits_left <= bits_left - BL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_tx_word_fifo_serializer.sv
// Scoreboard bench: accepted words expand into expected bit queues; a monitor
// pops one entry whenever a served rd_enable strobe produced a bit.
module tb_tx_word_fifo_serializer;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int LW = 3;

  typedef struct {
    logic b;
    logic last;
  } exp_bit_t;

  logic          clk;
  logic          reset;
  logic [W-1:0]  wr_data;
  logic          wr_valid;
  logic          rd_enable;

  logic          wr_ready, data_serial_out, word_last, underrun, empty, full;
  logic [LW-1:0] fifo_level;
  logic          wr_ready_m, data_serial_out_m, word_last_m, underrun_m, empty_m, full_m;
  logic [LW-1:0] fifo_level_m;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [W-1:0] m_fifo[$];
  int           m_bl      = 0;
  bit           m_underrun = 0;
  bit           m_rd      = 0;
  bit           m_rst     = 1;
  bit           mon_on    = 0;
  exp_bit_t     exp_q[$];
  exp_bit_t     exp_qm[$];

  tx_word_fifo_serializer #(.WORD_SIZE(W), .DEPTH(D), .MSB_FIRST(0)) dut (
    .clk(clk), .reset(reset), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .rd_enable(rd_enable), .data_serial_out(data_serial_out),
    .word_last(word_last), .underrun(underrun), .empty(empty), .full(full),
    .fifo_level(fifo_level)
  );

  tx_word_fifo_serializer #(.WORD_SIZE(W), .DEPTH(D), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .reset(reset), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready_m), .rd_enable(rd_enable), .data_serial_out(data_serial_out_m),
    .word_last(word_last_m), .underrun(underrun_m), .empty(empty_m), .full(full_m),
    .fifo_level(fifo_level_m)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: word queue plus count of bits still owed for the current word.
  task automatic model_step();
    int lvl;
    int bl;
    bit acc, sh, ld;
    logic [W-1:0] w;
    exp_bit_t e;
    if (reset) begin
      m_fifo.delete();
      exp_q.delete();
      exp_qm.delete();
      m_bl = 0;
      m_underrun = 0;
      m_rd = 0;
      m_rst = 1;
    end else begin
      lvl = m_fifo.size();
      bl  = m_bl;
      acc = wr_valid && (lvl < D);
      sh  = rd_enable && (bl > 0);
      m_underrun = rd_enable && (bl == 0);
      ld  = (lvl > 0) && ((bl == 0) || (sh && bl == 1));
      if (ld) begin
        void'(m_fifo.pop_front());
        m_bl = W;
      end else if (sh) begin
        m_bl = bl - 1;
      end
      if (acc) begin
        w = wr_data;
        m_fifo.push_back(w);
        for (int i = 0; i < W; i++) begin
          e.last = (i == W - 1);
          e.b = w[i];
          exp_q.push_back(e);
          e.b = w[W-1-i];
          exp_qm.push_back(e);
        end
      end
      m_rd  = rd_enable;
      m_rst = 0;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor: flags every cycle, serial bits whenever a strobe was served.
  initial begin
    logic prev_l, prev_m;
    exp_bit_t e;
    int sz;
    prev_l = 1'b0;
    prev_m = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        sz = m_fifo.size();
        check("empty", empty, (sz == 0 && m_bl == 0));
        check("full", full, (sz == D));
        check("wr_ready", wr_ready, (sz != D));
        check("fifo_level", fifo_level, sz);
        check("underrun", underrun, m_underrun);
        check("underrun_msb", underrun_m, m_underrun);
        check("fifo_level_msb", fifo_level_m, sz);
        if (m_rst) begin
          check("dout_reset", data_serial_out, 0);
          check("word_last_reset", word_last, 0);
          check("dout_reset_msb", data_serial_out_m, 0);
        end else if (m_rd && !underrun) begin
          if (exp_q.size() == 0 || exp_qm.size() == 0) begin
            check("unexpected_bit", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("serial_bit", data_serial_out, e.b);
            check("word_last", word_last, e.last);
            e = exp_qm.pop_front();
            check("serial_bit_msb", data_serial_out_m, e.b);
            check("word_last_msb", word_last_m, e.last);
          end
        end else begin
          check("dout_hold", data_serial_out, prev_l);
          check("word_last_idle", word_last, 0);
          check("dout_hold_msb", data_serial_out_m, prev_m);
        end
        prev_l = data_serial_out;
        prev_m = data_serial_out_m;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic push_word(input logic [W-1:0] w);
    int n;
    n = 0;
    wr_valid = 1'b1;
    wr_data  = w;
    while (!wr_ready && n < 100) begin
      cyc();
      n++;
    end
    if (n >= 100) check("push_timeout", 1, 0);
    cyc();
    wr_valid = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; wr_data = '0; wr_valid = 1'b0; rd_enable = 1'b0;
    cyc();
    mon_on = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;
    repeat (3) cyc();
    check("idle_empty", empty, 1);
    check("idle_level", fifo_level, 0);
    check("idle_dout", data_serial_out, 0);

    // Single word, strobes from E+2 onward.
    push_word(8'hA5);
    cyc();
    rd_enable = 1'b1;
    repeat (8) cyc();
    rd_enable = 1'b0;
    cyc();
    check("a5_empty", empty, 1);

    // Two words back to back, continuous strobes: no gap, no underrun.
    push_word(8'h0F);
    push_word(8'hF0);
    rd_enable = 1'b1;
    repeat (16) cyc();
    rd_enable = 1'b0;
    cyc();
    check("chain_empty", empty, 1);

    // Fill with strobes off: one word in the shifter plus DEPTH queued.
    for (int i = 0; i < 6; i++) begin
      wr_valid = 1'b1;
      wr_data  = W'(8'h30 + i);
      cyc();
    end
    check("fill_full", full, 1);
    check("fill_level", fifo_level, D);
    check("fill_ready", wr_ready, 0);
    wr_data = 8'h3F;
    rd_enable = 1'b1;
    n = 0;
    while (!wr_ready && n < 20) begin
      cyc();
      n++;
    end
    check("fill_unblock", wr_ready, 1);
    cyc();
    wr_valid = 1'b0;
    repeat (50) cyc();
    check("drain_empty", empty, 1);

    // Strobe while empty: one-cycle underrun pulse.
    rd_enable = 1'b0;
    cyc();
    rd_enable = 1'b1;
    cyc();
    check("underrun_pulse", underrun, 1);
    rd_enable = 1'b0;
    cyc();
    check("underrun_clear", underrun, 0);

    // Reset mid-word with two queued words.
    push_word(8'hC3);
    push_word(8'h11);
    push_word(8'h22);
    rd_enable = 1'b1;
    repeat (3) cyc();
    rd_enable = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("rst_empty", empty, 1);
    check("rst_level", fifo_level, 0);
    push_word(8'h81);
    cyc();
    rd_enable = 1'b1;
    repeat (8) cyc();
    rd_enable = 1'b0;
    cyc();

    // Randomised traffic with varying strobe density and rare resets.
    for (int seg = 0; seg < 6; seg++) begin
      int rd_pct;
      int wr_pct;
      rd_pct = $urandom_range(10, 100);
      wr_pct = $urandom_range(5, 60);
      for (int c = 0; c < 400; c++) begin
        wr_valid  = ($urandom_range(0, 99) < wr_pct);
        wr_data   = W'($urandom);
        rd_enable = ($urandom_range(0, 99) < rd_pct);
        reset     = ($urandom_range(0, 599) == 0);
        cyc();
      end
    end
    reset = 1'b0;
    wr_valid = 1'b0;
    rd_enable = 1'b1;
    repeat (60) cyc();
    rd_enable = 1'b0;
    cyc();
    check("final_drained", exp_q.size(), 0);
    check("final_empty", empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
